// File: rtl/ram_ctrl.sv
// Four-phase external SRAM controller. Each ONE..FOUR phase group from the bridge
// carries one access. The access is latched on ONE entry and sequenced on later entries.
module ram_ctrl #(
    parameter int unsigned RAM_ADDR_W = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            ramState_i,
    input  logic                  memEnable_i,
    input  logic                  memReadWrite_i,
    input  logic [15:0]           memAddress_i,
    input  logic [15:0]           memDataWrite_i,
    output logic [15:0]           memDataRead_o,
    output logic                  seqErr_o,
    output logic [RAM_ADDR_W-1:0] ramAddr_o,
    inout  wire  [15:0]           ramData,
    output logic                  ramCE_n,
    output logic                  ramOE_n,
    output logic                  ramWE_n
);

    typedef enum logic [1:0] {
        PH_ONE   = 2'b00,
        PH_TWO   = 2'b01,
        PH_THREE = 2'b11,
        PH_FOUR  = 2'b10
    } phase_e;

    typedef enum logic {
        ST_RUN,
        ST_ERR
    } state_e;

    phase_e                phase;
    phase_e                prev_q, prev_d;
    state_e                state_q, state_d;
    logic                  err_q, err_d;
    logic                  en_q, en_d;
    logic                  rw_q, rw_d;
    logic [15:0]           wd_q, wd_d;
    logic [RAM_ADDR_W-1:0] addr_q, addr_d;
    logic                  ce_q, ce_d;
    logic                  oe_q, oe_d;
    logic                  we_q, we_d;
    logic                  drv_q, drv_d;
    logic [15:0]           rd_q, rd_d;
    logic                  entry, accept_one, advance, to_err;

    assign phase = phase_e'(ramState_i);

    function automatic phase_e succ(input phase_e p);
        case (p)
            PH_ONE:   succ = PH_TWO;
            PH_TWO:   succ = PH_THREE;
            PH_THREE: succ = PH_FOUR;
            default:  succ = PH_ONE;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q  <= PH_FOUR;
            state_q <= ST_RUN;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            wd_q    <= '0;
            addr_q  <= '0;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            drv_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            prev_q  <= prev_d;
            state_q <= state_d;
            err_q   <= err_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            ce_q    <= ce_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            drv_q   <= drv_d;
            rd_q    <= rd_d;
        end
    end

    // A ONE entry is always honoured out of ERR, whatever phase preceded it.
    always_comb begin
        entry      = (phase != prev_q);
        accept_one = entry && (phase == PH_ONE) &&
                     ((state_q == ST_ERR) || (prev_q == PH_FOUR));
        advance    = entry && !accept_one && (state_q == ST_RUN) &&
                     (phase == succ(prev_q));
        to_err     = entry && !accept_one && !advance;
        prev_d     = phase;
        err_d      = err_q | to_err;
        state_d    = state_q;
        if (accept_one) begin
            state_d = ST_RUN;
        end else if (to_err) begin
            state_d = ST_ERR;
        end
    end

    always_comb begin
        en_d   = en_q;
        rw_d   = rw_q;
        wd_d   = wd_q;
        addr_d = addr_q;
        ce_d   = ce_q;
        oe_d   = oe_q;
        we_d   = we_q;
        drv_d  = drv_q;
        rd_d   = rd_q;
        if (accept_one) begin
            en_d   = memEnable_i;
            rw_d   = memReadWrite_i;
            wd_d   = memDataWrite_i;
            addr_d = RAM_ADDR_W'(memAddress_i);
            ce_d   = ~memEnable_i;
            oe_d   = 1'b1;
            we_d   = 1'b1;
            drv_d  = 1'b0;
        end else if (to_err) begin
            ce_d  = 1'b1;
            oe_d  = 1'b1;
            we_d  = 1'b1;
            drv_d = 1'b0;
        end else if (advance && en_q) begin
            case (phase)
                PH_TWO: begin
                    if (rw_q) drv_d = 1'b1;
                    else      oe_d  = 1'b0;
                end
                PH_THREE: begin
                    if (rw_q) we_d = 1'b0;
                end
                PH_FOUR: begin
                    if (rw_q) begin
                        we_d = 1'b1;
                    end else begin
                        rd_d = ramData;
                        oe_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ramData       = drv_q ? wd_q : 16'hzzzz;
    assign ramAddr_o     = addr_q;
    assign ramCE_n       = ce_q;
    assign ramOE_n       = oe_q;
    assign ramWE_n       = we_q;
    assign memDataRead_o = rd_q;
    assign seqErr_o      = err_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: directed vector table, hand sequences for stall and reset
// mid-write, then random phase/input traffic against a phase-group model.
module tb_ram_ctrl;

    localparam logic [1:0] P1 = 2'b00, P2 = 2'b01, P3 = 2'b11, P4 = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ph;
    logic        en, rw;
    logic [15:0] a, d;
    logic [15:0] memDataRead_o;
    logic        seqErr_o;
    logic [17:0] ramAddr_o;
    wire  [15:0] ramData;
    logic        ramCE_n, ramOE_n, ramWE_n;
    logic        probe_en = 1'b1;

    logic [15:0] sram    [65536];
    logic [15:0] ref_mem [65536];

    int cmp_n = 0;
    int bad_n = 0;

    // Bus probe: pulls the bus to 0 when nothing should drive it, so a stray
    // driver from the controller shows up as a nonzero value.
    assign ramData = (!ramCE_n && !ramOE_n && ramWE_n) ? sram[ramAddr_o[15:0]] :
                     (probe_en ? 16'h0000 : 16'hzzzz);

    ram_ctrl #(.RAM_ADDR_W(18)) dut (
        .clk(clk), .rst(rst), .ramState_i(ph), .memEnable_i(en),
        .memReadWrite_i(rw), .memAddress_i(a), .memDataWrite_i(d),
        .memDataRead_o(memDataRead_o), .seqErr_o(seqErr_o),
        .ramAddr_o(ramAddr_o), .ramData(ramData),
        .ramCE_n(ramCE_n), .ramOE_n(ramOE_n), .ramWE_n(ramWE_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [1:0]  ph;
        logic        en, rw;
        logic [15:0] a, d;
        logic [17:0] e_addr;
        logic        e_ce, e_oe, e_we, e_drv;
        logic [15:0] e_bus, e_rd;
        logic        e_err;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic r, input logic [1:0] p, input logic e, input logic w,
                                input logic [15:0] ad, input logic [15:0] dd, input logic [17:0] ea,
                                input logic ce, input logic oe, input logic we, input logic drv,
                                input logic [15:0] bus, input logic [15:0] rd, input logic er);
        vec_t v;
        v.r = r; v.ph = p; v.en = e; v.rw = w; v.a = ad; v.d = dd; v.e_addr = ea;
        v.e_ce = ce; v.e_oe = oe; v.e_we = we; v.e_drv = drv; v.e_bus = bus;
        v.e_rd = rd; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // SRAM array takes the bus value on every cycle its write strobe is low.
    task automatic mem_tick();
        if (ramCE_n === 1'b0 && ramWE_n === 1'b0) sram[ramAddr_o[15:0]] = ramData;
    endtask

    // Reference model: tracks where in the ONE..FOUR group the bridge is,
    // what transaction was accepted, and the resulting SRAM pin levels.
    logic [1:0]  m_prev;
    logic        m_inerr, m_err, m_en, m_rw;
    logic [15:0] m_wd, m_rd, m_addr;
    logic        m_ce, m_oe, m_we, m_drv;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        case (p)
            P1:      nxt = P2;
            P2:      nxt = P3;
            P3:      nxt = P4;
            default: nxt = P1;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic [1:0] p, input logic e, input logic w,
                              input logic [15:0] ad, input logic [15:0] dd);
        if (!r) begin
            m_prev = P4; m_inerr = 0; m_err = 0; m_en = 0; m_rw = 0; m_wd = 0;
            m_rd = 0; m_addr = 0; m_ce = 1; m_oe = 1; m_we = 1; m_drv = 0;
            return;
        end
        if (p != m_prev) begin
            if (p == P1 && (m_inerr || m_prev == P4)) begin
                m_inerr = 0; m_en = e; m_rw = w; m_wd = dd; m_addr = ad;
                m_ce = !e; m_oe = 1; m_we = 1; m_drv = 0;
            end else if (!m_inerr && p == nxt(m_prev)) begin
                if (m_en && p == P2) begin
                    if (m_rw) m_drv = 1; else m_oe = 0;
                end else if (m_en && p == P3 && m_rw) begin
                    m_we = 0;
                    ref_mem[m_addr] = m_wd;
                end else if (m_en && p == P4) begin
                    if (m_rw) m_we = 1;
                    else begin m_rd = ref_mem[m_addr]; m_oe = 1; end
                end
            end else begin
                m_inerr = 1; m_err = 1; m_ce = 1; m_oe = 1; m_we = 1; m_drv = 0;
            end
        end
        m_prev = p;
    endtask

    task automatic step(input logic r, input logic [1:0] p, input logic e, input logic w,
                        input logic [15:0] ad, input logic [15:0] dd);
        logic [15:0] e_bus;
        rst = r; ph = p; en = e; rw = w; a = ad; d = dd;
        @(posedge clk);
        model_edge(r, p, e, w, ad, dd);
        probe_en = !m_drv;
        #1;
        if (m_drv)                e_bus = m_wd;
        else if (!m_ce && !m_oe)  e_bus = ref_mem[m_addr];
        else                      e_bus = 16'h0000;
        chk("addr", 32'(ramAddr_o), 32'(m_addr));
        chk("ce_n", 32'(ramCE_n), 32'(m_ce));
        chk("oe_n", 32'(ramOE_n), 32'(m_oe));
        chk("we_n", 32'(ramWE_n), 32'(m_we));
        chk("bus", 32'(ramData), 32'(e_bus));
        chk("rdata", 32'(memDataRead_o), 32'(m_rd));
        chk("seqErr", 32'(seqErr_o), 32'(m_err));
        mem_tick();
    endtask

    initial begin
        logic [1:0] cur;
        int         r;
        rst = 0; ph = P4; en = 0; rw = 0; a = 0; d = 0;
        for (int unsigned i = 0; i < 65536; i++) begin
            sram[i]    = 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        sram[16'h0040] = 16'h1234;

        tbl[0]  = mk(0, P4, 0, 0, 16'h0000, 16'h0000, 18'h00000, 1, 1, 1, 0, 16'h0000, 16'h0000, 0);
        tbl[1]  = mk(1, P1, 1, 1, 16'h0012, 16'hBEEF, 18'h00012, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);
        tbl[2]  = mk(1, P2, 1, 0, 16'hFFFF, 16'h0000, 18'h00012, 0, 1, 1, 1, 16'hBEEF, 16'h0000, 0);
        tbl[3]  = mk(1, P3, 0, 0, 16'hFFFF, 16'h0000, 18'h00012, 0, 1, 0, 1, 16'hBEEF, 16'h0000, 0);
        tbl[4]  = mk(1, P4, 0, 0, 16'hFFFF, 16'h0000, 18'h00012, 0, 1, 1, 1, 16'hBEEF, 16'h0000, 0);
        tbl[5]  = mk(1, P1, 1, 0, 16'h0040, 16'h0000, 18'h00040, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);
        tbl[6]  = mk(1, P2, 0, 1, 16'h1111, 16'h2222, 18'h00040, 0, 0, 1, 0, 16'h1234, 16'h0000, 0);
        tbl[7]  = mk(1, P3, 0, 1, 16'h1111, 16'h2222, 18'h00040, 0, 0, 1, 0, 16'h1234, 16'h0000, 0);
        tbl[8]  = mk(1, P4, 0, 1, 16'h1111, 16'h2222, 18'h00040, 0, 1, 1, 0, 16'h0000, 16'h1234, 0);
        tbl[9]  = mk(1, P1, 0, 1, 16'h0012, 16'h5555, 18'h00012, 1, 1, 1, 0, 16'h0000, 16'h1234, 0);
        tbl[10] = mk(1, P2, 1, 1, 16'h0012, 16'h5555, 18'h00012, 1, 1, 1, 0, 16'h0000, 16'h1234, 0);
        tbl[11] = mk(1, P3, 1, 1, 16'h0012, 16'h5555, 18'h00012, 1, 1, 1, 0, 16'h0000, 16'h1234, 0);
        tbl[12] = mk(1, P4, 1, 1, 16'h0012, 16'h5555, 18'h00012, 1, 1, 1, 0, 16'h0000, 16'h1234, 0);
        tbl[13] = mk(1, P1, 1, 0, 16'h0012, 16'h0000, 18'h00012, 0, 1, 1, 0, 16'h0000, 16'h1234, 0);
        tbl[14] = mk(1, P3, 1, 0, 16'h0012, 16'h0000, 18'h00012, 1, 1, 1, 0, 16'h0000, 16'h1234, 1);
        tbl[15] = mk(1, P4, 1, 0, 16'h0012, 16'h0000, 18'h00012, 1, 1, 1, 0, 16'h0000, 16'h1234, 1);
        tbl[16] = mk(1, P1, 1, 0, 16'h0012, 16'h0000, 18'h00012, 0, 1, 1, 0, 16'h0000, 16'h1234, 1);
        tbl[17] = mk(1, P2, 0, 1, 16'h3333, 16'h4444, 18'h00012, 0, 0, 1, 0, 16'hBEEF, 16'h1234, 1);
        tbl[18] = mk(1, P3, 0, 1, 16'h3333, 16'h4444, 18'h00012, 0, 0, 1, 0, 16'hBEEF, 16'h1234, 1);
        tbl[19] = mk(1, P4, 0, 1, 16'h3333, 16'h4444, 18'h00012, 0, 1, 1, 0, 16'h0000, 16'hBEEF, 1);

        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].r; ph = tbl[i].ph; en = tbl[i].en; rw = tbl[i].rw;
            a = tbl[i].a; d = tbl[i].d;
            @(posedge clk);
            probe_en = !tbl[i].e_drv;
            #1;
            chk("t_addr", 32'(ramAddr_o), 32'(tbl[i].e_addr));
            chk("t_ce_n", 32'(ramCE_n), 32'(tbl[i].e_ce));
            chk("t_oe_n", 32'(ramOE_n), 32'(tbl[i].e_oe));
            chk("t_we_n", 32'(ramWE_n), 32'(tbl[i].e_we));
            chk("t_bus", 32'(ramData), 32'(tbl[i].e_bus));
            chk("t_rdata", 32'(memDataRead_o), 32'(tbl[i].e_rd));
            chk("t_seqErr", 32'(seqErr_o), 32'(tbl[i].e_err));
            mem_tick();
        end

        // Stall in FOUR, then a normal write group.
        step(0, P4, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 16; i++)
            step(1, P4, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
        step(1, P1, 1, 1, 16'hFF10, 16'h1357);
        for (int i = 0; i < 4; i++) step(1, P2, 0, 0, 16'hFF11, 16'h0000);
        step(1, P3, 0, 0, 16'hFF11, 16'h0000);
        for (int i = 0; i < 3; i++) step(1, P3, 0, 0, 16'hFF11, 16'h0000);
        step(1, P4, 0, 0, 16'hFF11, 16'h0000);

        // Reset while the write strobe is low, then read the location back.
        step(1, P1, 1, 1, 16'hFF05, 16'hABCD);
        step(1, P2, 1, 1, 16'hFF05, 16'hABCD);
        step(1, P3, 1, 1, 16'hFF05, 16'hABCD);
        step(0, P3, 1, 1, 16'hFF05, 16'hABCD);
        step(1, P1, 1, 0, 16'hFF05, 16'h0000);
        step(1, P2, 0, 0, 16'h0000, 16'h0000);
        step(1, P3, 0, 0, 16'h0000, 16'h0000);
        step(1, P4, 0, 0, 16'h0000, 16'h0000);
        step(1, P1, 1, 0, 16'hFF10, 16'h0000);
        step(1, P2, 0, 0, 16'h0000, 16'h0000);
        step(1, P3, 0, 0, 16'h0000, 16'h0000);
        step(1, P4, 0, 0, 16'h0000, 16'h0000);

        // Random traffic: mostly legal sequencing, with stalls, jumps and resets.
        cur = P4;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      cur = nxt(cur);
            else if (r < 97) cur = (r < 85) ? cur : 2'($urandom);
            step((r < 98), cur, ($urandom_range(0, 3) != 0), 1'($urandom),
                 16'hFF00 + 16'($urandom_range(0, 31)), 16'($urandom));
            if (r >= 98) cur = P4;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter: RAM_ADDR_W, default 18, external SRAM address width; SHALL be >= 16.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-low.
REQ-004 ramState_i  input  2  phase from bridge: ONE=2'b00, TWO=2'b01, THREE=2'b11, FOUR=2'b10.
REQ-005 memEnable_i  input  1  access request; 1 = access this cycle group.
REQ-006 memReadWrite_i  input  1  0 = read, 1 = write.
REQ-007 memAddress_i  input  16  word address.
REQ-008 memDataWrite_i  input  16  write data.
REQ-009 memDataRead_o  output  16  registered read data.
REQ-010 seqErr_o  output  1  sticky phase-sequence error flag.
REQ-011 ramAddr_o  output  RAM_ADDR_W  SRAM address; upper RAM_ADDR_W-16 bits always 0.
REQ-012 ramData  inout  16  SRAM data bus; hi-Z unless this block drives it.
REQ-013 ramCE_n, ramOE_n, ramWE_n  output  1 each  SRAM chip/output/write enables, active-low.

Function
REQ-014 Block SHALL keep prevPhase register; an "entry" is an edge where ramState_i != prevPhase; prevPhase SHALL update every edge.
REQ-015 Repeated phase value (no entry) SHALL hold all outputs and latches unchanged (stall, e.g. during flash wait).
REQ-016 Legal entries: ONE->TWO, TWO->THREE, THREE->FOUR, FOUR->ONE; any other entry SHALL set seqErr_o and enter ERR.
REQ-017 Entry to ONE SHALL: latch memAddress_i, memDataWrite_i, memReadWrite_i, memEnable_i; ramAddr_o <= zero-extended memAddress_i; ramCE_n <= ~memEnable_i; ramOE_n <= 1; ramWE_n <= 1; release ramData.
REQ-018 Entry to TWO, latched read & enable: ramOE_n <= 0; latched write & enable: drive ramData with latched data, ramWE_n stays 1.
REQ-019 Entry to THREE, write & enable: ramWE_n <= 0; read: outputs held.
REQ-020 Entry to FOUR, write & enable: ramWE_n <= 1, data and address still held (hold time); read & enable: memDataRead_o <= ramData, ramOE_n <= 1.
REQ-021 memDataRead_o SHALL change only at FOUR entry of an enabled read; valid from that edge until next such edge.
REQ-022 Latched enable = 0: ramCE_n/OE_n/WE_n SHALL stay 1 and ramData hi-Z for whole group; memDataRead_o unchanged.
REQ-023 ramWE_n and ramOE_n SHALL never be 0 simultaneously; ramData SHALL never be driven while ramOE_n = 0.
REQ-024 ERR: ramCE_n/OE_n/WE_n = 1, ramData hi-Z, regardless of phases, until next entry to ONE, which SHALL be processed normally (REQ-017); seqErr_o SHALL stay 1 until reset.
REQ-025 Address and write data SHALL be taken only from the ONE-entry latch; input changes in TWO..FOUR SHALL not affect pins.

Reset
REQ-026 With rst = 0 at an edge: ramAddr_o = 0, ramCE_n = ramOE_n = ramWE_n = 1, ramData hi-Z, memDataRead_o = 16'h0000, seqErr_o = 0, prevPhase = FOUR, latches cleared.
REQ-027 Reset mid-write SHALL deassert ramWE_n at that same edge (write may be truncated); first ONE after reset is a legal entry.

Verification
REQ-028 Write: ONE with en=1, rw=1, addr=16'h0012, data=16'hBEEF, then TWO,THREE,FOUR -> ramAddr_o=0x00012, ramData=BEEF from TWO entry through next ONE, ramWE_n low exactly THREE..FOUR entry, ramOE_n=1 throughout.
REQ-029 Read: SRAM model holds 16'h1234 at 0x0040; group with en=1, rw=0, addr=16'h0040 -> ramOE_n low TWO..FOUR entry, memDataRead_o=16'h1234 after FOUR entry, ramData never driven.
REQ-030 Stall: hold ramState_i=FOUR 16 cycles then ONE,TWO,THREE,FOUR with en=1 write -> no pin change during stall, write proceeds normally, seqErr_o=0.
REQ-031 Illegal: ONE then THREE -> seqErr_o=1, enables all 1, bus hi-Z; then FOUR, ONE (en=1 read), TWO.. -> read completes, seqErr_o remains 1.
REQ-032 Disabled: group with en=0, rw=1 -> ramCE_n=ramWE_n=1, bus hi-Z, memDataRead_o unchanged.
REQ-033 Reset during THREE of write -> next edge ramWE_n=1, all outputs at REQ-026 values; subsequent ONE..FOUR read works.
